// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package reg_wb_pkg;
  localparam int REG_DW = 8;
  localparam int REG_AW = 3;
  localparam int REG_N  = 8;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  typedef enum logic {SRC_A = 1'b0, SRC_M = 1'b1} wb_src_e;
endpackage

// File: rtl/reg_wb_arbiter_hold_slot.sv
// One-entry writeback holding slot: valid/addr/data register with load/free
// and source-address compare for hazard/forward detection.
module wb_hold_slot
  import reg_wb_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_load,
  input  logic          i_free,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic          o_vld,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_match1,
  output logic          o_match2
);
  logic          r_vld;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // A reload in the same edge as the free keeps the slot occupied.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vld  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_free) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld    = r_vld;
  assign o_addr   = r_addr;
  assign o_data   = r_data;
  assign o_match1 = r_vld && (r_addr == i_raddr1);
  assign o_match2 = r_vld && (r_addr == i_raddr2);
endmodule

// File: rtl/reg_wb_arbiter.sv
// Oldest-first (round-robin on ties) arbiter sharing the register-file write port
// between ALU and load writeback; REG_WB_BYPASS_EN adds forwarding outputs.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          A_VALID,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_DATA,
  output logic          A_READY,
  input  logic          M_VALID,
  input  logic [AW-1:0] M_ADDR,
  input  logic [DW-1:0] M_DATA,
  output logic          M_READY,
  output logic          WRITE,
  output logic [AW-1:0] INADDRESS,
  output logic [DW-1:0] IN,
  input  logic [AW-1:0] RADDR1,
  input  logic [AW-1:0] RADDR2,
  output logic          HAZARD,
`ifdef REG_WB_BYPASS_EN
  output logic          FWD1_VALID,
  output logic [DW-1:0] FWD1_DATA,
  output logic          FWD2_VALID,
  output logic [DW-1:0] FWD2_DATA,
`endif
  output logic          IDLE
);
  logic          w_a_vld, w_m_vld;
  logic [AW-1:0] w_a_addr, w_m_addr;
  logic [DW-1:0] w_a_data, w_m_data;
  logic          w_a_m1, w_a_m2, w_m_m1, w_m_m2;
  logic          w_a_grant, w_m_grant;
  logic          w_a_load, w_m_load;
  logic          w_i_m1, w_i_m2;

  logic          r_m_older;
  logic          r_tie;
  wb_src_e       r_last_grant;
  logic          r_write;
  logic [AW-1:0] r_inaddr;
  logic [DW-1:0] r_in;

  wb_hold_slot #(.DW(DW), .AW(AW)) u_slot_a (
    .CLK(CLK), .RESET(RESET), .i_load(w_a_load), .i_free(w_a_grant),
    .i_addr(A_ADDR), .i_data(A_DATA), .i_raddr1(RADDR1), .i_raddr2(RADDR2),
    .o_vld(w_a_vld), .o_addr(w_a_addr), .o_data(w_a_data),
    .o_match1(w_a_m1), .o_match2(w_a_m2)
  );

  wb_hold_slot #(.DW(DW), .AW(AW)) u_slot_m (
    .CLK(CLK), .RESET(RESET), .i_load(w_m_load), .i_free(w_m_grant),
    .i_addr(M_ADDR), .i_data(M_DATA), .i_raddr1(RADDR1), .i_raddr2(RADDR2),
    .o_vld(w_m_vld), .o_addr(w_m_addr), .o_data(w_m_data),
    .o_match1(w_m_m1), .o_match2(w_m_m2)
  );

  always_comb begin
    w_a_grant = 1'b0;
    w_m_grant = 1'b0;
    if (w_a_vld && w_m_vld) begin
      if (r_tie) begin
        if (r_last_grant == SRC_M) w_a_grant = 1'b1;
        else                       w_m_grant = 1'b1;
      end else if (r_m_older) begin
        w_m_grant = 1'b1;
      end else begin
        w_a_grant = 1'b1;
      end
    end else begin
      w_a_grant = w_a_vld;
      w_m_grant = w_m_vld;
    end
  end

  assign A_READY  = !RESET && (!w_a_vld || w_a_grant);
  assign M_READY  = !RESET && (!w_m_vld || w_m_grant);
  assign w_a_load = A_VALID && A_READY;
  assign w_m_load = M_VALID && M_READY;

  // Age only matters while both slots hold data; a lone load makes the
  // other (surviving) slot the older one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_m_older    <= 1'b0;
      r_tie        <= 1'b0;
      r_last_grant <= SRC_M;
      r_write      <= 1'b0;
      r_inaddr     <= '0;
      r_in         <= '0;
    end else begin
      if (w_a_load && w_m_load) begin
        r_tie <= 1'b1;
      end else if (w_a_load) begin
        r_tie     <= 1'b0;
        r_m_older <= w_m_vld && !w_m_grant;
      end else if (w_m_load) begin
        r_tie     <= 1'b0;
        r_m_older <= 1'b0;
      end
      r_write <= w_a_grant || w_m_grant;
      if (w_a_grant) begin
        r_inaddr     <= w_a_addr;
        r_in         <= w_a_data;
        r_last_grant <= SRC_A;
      end else if (w_m_grant) begin
        r_inaddr     <= w_m_addr;
        r_in         <= w_m_data;
        r_last_grant <= SRC_M;
      end
    end
  end

  assign WRITE     = r_write;
  assign INADDRESS = r_inaddr;
  assign IN        = r_in;
  assign IDLE      = !w_a_vld && !w_m_vld && !r_write;

  assign w_i_m1 = r_write && (r_inaddr == RADDR1);
  assign w_i_m2 = r_write && (r_inaddr == RADDR2);

`ifdef REG_WB_BYPASS_EN
  logic w_a_younger;
  logic [DW:0] w_fwd1, w_fwd2;

  // On a same-cycle tie the last_grant side commits second, so it is younger.
  assign w_a_younger = r_tie ? (r_last_grant == SRC_A) : r_m_older;

  function automatic logic [DW:0] f_fwd(input logic i_am, input logic i_mm,
                                        input logic i_im, input logic i_ay,
                                        input logic [DW-1:0] i_ad,
                                        input logic [DW-1:0] i_md,
                                        input logic [DW-1:0] i_id);
    logic [DW:0] v;
    v = '0;
    if (i_am && i_mm) v = i_ay ? {1'b1, i_ad} : {1'b1, i_md};
    else if (i_am)    v = {1'b1, i_ad};
    else if (i_mm)    v = {1'b1, i_md};
    else if (i_im)    v = {1'b1, i_id};
    return v;
  endfunction

  assign w_fwd1 = f_fwd(w_a_m1, w_m_m1, w_i_m1, w_a_younger, w_a_data, w_m_data, r_in);
  assign w_fwd2 = f_fwd(w_a_m2, w_m_m2, w_i_m2, w_a_younger, w_a_data, w_m_data, r_in);
  assign FWD1_VALID = w_fwd1[DW];
  assign FWD1_DATA  = w_fwd1[DW-1:0];
  assign FWD2_VALID = w_fwd2[DW];
  assign FWD2_DATA  = w_fwd2[DW-1:0];
  // Every match is forwarded, so a hazard remains only for an unforwarded match.
  assign HAZARD = ((w_a_m1 || w_m_m1 || w_i_m1) && !FWD1_VALID) ||
                  ((w_a_m2 || w_m_m2 || w_i_m2) && !FWD2_VALID);
`else
  assign HAZARD = w_a_m1 || w_m_m1 || w_i_m1 || w_a_m2 || w_m_m2 || w_i_m2;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter.
module tb_reg_wb_arbiter;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       A_VALID, M_VALID;
  logic [2:0] A_ADDR, M_ADDR;
  logic [7:0] A_DATA, M_DATA;
  logic       A_READY, M_READY;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [2:0] RADDR1, RADDR2;
  logic       HAZARD, IDLE;
`ifdef REG_WB_BYPASS_EN
  logic       FWD1_VALID, FWD2_VALID;
  logic [7:0] FWD1_DATA, FWD2_DATA;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_run = 0;
  int n_fail = 0;
  logic [7:0]  rf [8];
  logic [10:0] wlog [$];
  int          lsz;

  always #5 CLK = ~CLK;

  reg_wb_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
    .M_VALID(M_VALID), .M_ADDR(M_ADDR), .M_DATA(M_DATA), .M_READY(M_READY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .RADDR1(RADDR1), .RADDR2(RADDR2), .HAZARD(HAZARD),
`ifdef REG_WB_BYPASS_EN
    .FWD1_VALID(FWD1_VALID), .FWD1_DATA(FWD1_DATA),
    .FWD2_VALID(FWD2_VALID), .FWD2_DATA(FWD2_DATA),
`endif
    .IDLE(IDLE)
  );

  // Register-file model fed by the write port, plus a log of every write.
  always @(negedge CLK) begin
    if (WRITE) begin
      rf[INADDRESS] <= IN;
      wlog.push_back({INADDRESS, IN});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    RESET = 1'b1;
    A_VALID = 0; A_ADDR = 0; A_DATA = 0;
    M_VALID = 0; M_ADDR = 0; M_DATA = 0;
    RADDR1 = 0; RADDR2 = 0;
    tick();
    @(negedge CLK);
    chk("rst_a_ready", A_READY, 0);
    chk("rst_m_ready", M_READY, 0);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_write", WRITE, 0);
    chk("rst_inaddr", INADDRESS, 0);
    chk("rst_in", IN, 0);
    chk("rst_idle", IDLE, 1);
    chk("rst_hazard", HAZARD, 0);
    chk("rst_a_ready1", A_READY, 1);

    // Tie after reset: A wins, M follows one cycle later.
    A_VALID = 1; A_ADDR = 1; A_DATA = 8'h11;
    M_VALID = 1; M_ADDR = 2; M_DATA = 8'h22;
    tick();
    A_VALID = 0; M_VALID = 0;
    @(negedge CLK);
    chk("tie_a_ready", A_READY, 1);
    chk("tie_m_ready", M_READY, 0);
    chk("tie_nowrite", WRITE, 0);
    tick();
    @(negedge CLK);
    chk("tie1_write", WRITE, 1);
    chk("tie1_addr", INADDRESS, 1);
    chk("tie1_data", IN, 8'h11);
    tick();
    @(negedge CLK);
    chk("tie2_write", WRITE, 1);
    chk("tie2_addr", INADDRESS, 2);
    chk("tie2_data", IN, 8'h22);
    tick();
    @(negedge CLK);
    chk("tie_idle", IDLE, 1);

    // Single write with in-flight hazard tracking.
    A_VALID = 1; A_ADDR = 3; A_DATA = 8'h5A;
    tick();
    A_VALID = 0; RADDR1 = 3;
    @(negedge CLK);
    chk("single_nowrite", WRITE, 0);
    chk("single_busy", IDLE, 0);
    chk("single_hz_slot", HAZARD, BYP ? 0 : 1);
    tick();
    @(negedge CLK);
    chk("single_write", WRITE, 1);
    chk("single_addr", INADDRESS, 3);
    chk("single_data", IN, 8'h5A);
    chk("single_hz_fly", HAZARD, BYP ? 0 : 1);
    tick();
    @(negedge CLK);
    chk("single_done", WRITE, 0);
    chk("single_hold", INADDRESS, 3);
    chk("single_idle", IDLE, 1);
    chk("single_hz_clr", HAZARD, 0);
    RADDR1 = 0;

    // Repeated tie after an A-only grant: M goes first.
    A_VALID = 1; A_ADDR = 6; A_DATA = 8'h66;
    M_VALID = 1; M_ADDR = 7; M_DATA = 8'h77;
    tick();
    A_VALID = 0; M_VALID = 0;
    @(negedge CLK);
    chk("rtie_a_ready", A_READY, 0);
    chk("rtie_m_ready", M_READY, 1);
    tick();
    @(negedge CLK);
    chk("rtie1_addr", INADDRESS, 7);
    chk("rtie1_data", IN, 8'h77);
    tick();
    @(negedge CLK);
    chk("rtie2_addr", INADDRESS, 6);
    chk("rtie2_data", IN, 8'h66);
    tick();

    // Streaming: 8 back-to-back ALU writes.
    lsz = wlog.size();
    for (int i = 0; i < 8; i++) begin
      A_VALID = 1; A_ADDR = 3'(i); A_DATA = 8'h80 + 8'(i);
      @(negedge CLK);
      chk("stream_ready", A_READY, 1);
      if (i >= 2) begin
        chk("stream_write", WRITE, 1);
        chk("stream_addr", INADDRESS, 16'(i - 2));
      end
      tick();
    end
    A_VALID = 0;
    tick(); tick(); tick();
    chk("stream_count", 16'(wlog.size() - lsz), 8);
    for (int i = 0; i < 8; i++)
      chk("stream_log", 16'(wlog[lsz + i]), 16'({3'(i), 8'h80 + 8'(i)}));

    // Same-address ordering: M then A one cycle later.
    M_VALID = 1; M_ADDR = 4; M_DATA = 8'hAA;
    tick();
    M_VALID = 0;
    A_VALID = 1; A_ADDR = 4; A_DATA = 8'hBB;
    @(negedge CLK);
    chk("ord_a_ready", A_READY, 1);
    tick();
    A_VALID = 0;
    @(negedge CLK);
    chk("ord1_data", IN, 8'hAA);
    tick();
    @(negedge CLK);
    chk("ord2_data", IN, 8'hBB);
    tick();

    // Hazard on a held load slot and then on the in-flight write.
    M_VALID = 1; M_ADDR = 5; M_DATA = 8'h3C;
    tick();
    M_VALID = 0; RADDR1 = 5; RADDR2 = 1;
    @(negedge CLK);
    chk("hz_slot", HAZARD, BYP ? 0 : 1);
`ifdef REG_WB_BYPASS_EN
    chk("fwd1_valid", FWD1_VALID, 1);
    chk("fwd1_data", FWD1_DATA, 8'h3C);
    chk("fwd2_none", FWD2_VALID, 0);
`endif
    tick();
    RADDR1 = 0; RADDR2 = 5;
    @(negedge CLK);
    chk("hz_fly", HAZARD, BYP ? 0 : 1);
`ifdef REG_WB_BYPASS_EN
    chk("fwd2_valid", FWD2_VALID, 1);
    chk("fwd2_data", FWD2_DATA, 8'h3C);
`endif
    tick();
    @(negedge CLK);
    chk("hz_stale_addr", INADDRESS, 5);
    chk("hz_clear", HAZARD, 0);
    RADDR1 = 0; RADDR2 = 0;

    // Reset with both slots occupied drops both requests.
    A_VALID = 1; A_ADDR = 2; A_DATA = 8'hD1;
    M_VALID = 1; M_ADDR = 3; M_DATA = 8'hD2;
    tick();
    A_VALID = 0; M_VALID = 0; RESET = 1;
    @(negedge CLK);
    chk("mrst_busy", IDLE, 0);
    chk("mrst_a_ready", A_READY, 0);
    chk("mrst_m_ready", M_READY, 0);
    lsz = wlog.size();
    tick();
    RESET = 0; RADDR1 = 2; RADDR2 = 3;
    @(negedge CLK);
    chk("mrst_write", WRITE, 0);
    chk("mrst_idle", IDLE, 1);
    chk("mrst_hazard", HAZARD, 0);
    tick(); tick();
    chk("mrst_nolog", 16'(wlog.size() - lsz), 0);

    chk("rf0", rf[0], 8'h80);
    chk("rf2", rf[2], 8'h82);
    chk("rf3", rf[3], 8'h83);
    chk("rf4", rf[4], 8'hBB);
    chk("rf5", rf[5], 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
